// File: rtl/bottleneck_pkg.sv
// Shared constants, width helpers and FSM state type for the bottleneck feed controller.
package bottleneck_pkg;

  function automatic int unsigned dilated_k(input int unsigned k, input int unsigned d);
    return (k - 1) * (d - 1) + k;
  endfunction

  function automatic int unsigned num_taps(input int unsigned kw, input int unsigned kh);
    return kw * kh;
  endfunction

  function automatic int unsigned iact_addr_w(input int unsigned tile_bw);
    return tile_bw + 4;
  endfunction

  function automatic int unsigned wght_addr_w(input int unsigned dkw, input int unsigned dkh);
    return $clog2(dkw * dkh);
  endfunction

  localparam int unsigned NUM_TAPS = num_taps(3, 3);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StPresent,
    StDrain,
    StFin
  } state_e;

endpackage

// File: rtl/bottleneck_feed_ctrl_dilated_tap_gen.sv
// Row/column walker over the non-zero taps of a dilated kernel; address built by accumulation.
module dilated_tap_gen
  import bottleneck_pkg::*;
#(
  parameter int unsigned KW       = 3,
  parameter int unsigned KH       = 3,
  parameter int unsigned DILATION = 3,
  localparam int unsigned DKW     = dilated_k(KW, DILATION),
  localparam int unsigned DKH     = dilated_k(KH, DILATION),
  localparam int unsigned ADDR_W  = wght_addr_w(DKW, DKH),
  localparam int unsigned PIX_W   = $clog2(num_taps(KW, KH)),
  localparam int unsigned RC_W    = $clog2((KW > KH ? KW : KH) + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic [PIX_W-1:0]  o_pixel,
  output logic [ADDR_W-1:0] o_tap_addr
);

  logic [RC_W-1:0]   r_row;
  logic [RC_W-1:0]   r_col;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_col_off;
  logic [PIX_W-1:0]  r_pixel;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_row      <= '0;
      r_col      <= '0;
      r_row_base <= '0;
      r_col_off  <= '0;
      r_pixel    <= '0;
    end else if (i_advance) begin
      if (r_col == RC_W'(KW - 1)) begin
        r_col     <= '0;
        r_col_off <= '0;
        // Wrapping after the last tap leaves the walker ready for the next tile.
        if (r_row == RC_W'(KH - 1)) begin
          r_row      <= '0;
          r_row_base <= '0;
          r_pixel    <= '0;
        end else begin
          r_row      <= r_row + 1'b1;
          r_row_base <= r_row_base + ADDR_W'(DILATION * DKW);
          r_pixel    <= r_pixel + 1'b1;
        end
      end else begin
        r_col     <= r_col + 1'b1;
        r_col_off <= r_col_off + ADDR_W'(DILATION);
        r_pixel   <= r_pixel + 1'b1;
      end
    end
  end

  assign o_pixel    = r_pixel;
  assign o_tap_addr = r_row_base + r_col_off;

endmodule

// File: rtl/bottleneck_feed_ctrl.sv
// Sequencer feeding (pixel, tap) beats from the iact/weight buffers to the bottleneck layer.
module bottleneck_feed_ctrl
  import bottleneck_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH  = 8,
  parameter int unsigned NUM_OF_CHANNEL = 32,
  parameter int unsigned NUM_OF_WEIGHT  = 32,
  parameter int unsigned KW             = 3,
  parameter int unsigned KH             = 3,
  parameter int unsigned DILATION       = 3,
  parameter int unsigned TILE_BITWIDTH  = 8,
  parameter int unsigned OACT_LATENCY   = 4,
  localparam int unsigned DKW    = dilated_k(KW, DILATION),
  localparam int unsigned DKH    = dilated_k(KH, DILATION),
  localparam int unsigned IA_W   = iact_addr_w(TILE_BITWIDTH),
  localparam int unsigned WA_W   = wght_addr_w(DKW, DKH),
  localparam int unsigned IACT_W = NUM_OF_CHANNEL * DATA_BITWIDTH,
  localparam int unsigned WGHT_W = NUM_OF_WEIGHT * NUM_OF_CHANNEL * DATA_BITWIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [TILE_BITWIDTH-1:0] i_num_tiles,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_iact_rd_en,
  output logic [IA_W-1:0]          o_iact_rd_addr,
  input  logic [IACT_W-1:0]        i_iact_rd_data,
  output logic                     o_wght_rd_en,
  output logic [WA_W-1:0]          o_wght_rd_addr,
  input  logic [WGHT_W-1:0]        i_wght_rd_data,
  output logic [IACT_W-1:0]        o_iacts,
  output logic [WGHT_W-1:0]        o_wghts,
  output logic                     o_iact_valid,
  input  logic                     i_request_next_iact,
  output logic                     o_oact_valid,
  output logic [TILE_BITWIDTH-1:0] o_oact_tile
);

  localparam int unsigned PIX_W = $clog2(num_taps(KW, KH));
  localparam int unsigned CNT_W = $clog2(OACT_LATENCY + 1);

  state_e                   r_state;
  logic [TILE_BITWIDTH-1:0] r_num_tiles;
  logic [TILE_BITWIDTH-1:0] r_tile;
  logic [TILE_BITWIDTH-1:0] r_oact_tile;
  logic [IA_W-1:0]          r_iact_addr;
  logic                     r_last;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_iact_valid;
  logic                     r_oact_valid;
  logic [IACT_W-1:0]        r_iacts;
  logic [WGHT_W-1:0]        r_wghts;

  logic             w_hs;
  logic             w_rd_en;
  logic             w_clear;
  logic [PIX_W-1:0] w_pixel;
  logic [WA_W-1:0]  w_tap_addr;
  logic             w_fetch_last;

  assign w_hs    = r_iact_valid && i_request_next_iact;
  // The next beat is fetched in the handshake cycle itself so there is no FETCH bubble.
  assign w_rd_en = (r_state == StFetch) || ((r_state == StPresent) && w_hs && !r_last);
  assign w_clear = (r_state == StIdle) && i_start;
  assign w_fetch_last = (w_pixel == PIX_W'(num_taps(KW, KH) - 1));

  dilated_tap_gen #(
    .KW       (KW),
    .KH       (KH),
    .DILATION (DILATION)
  ) u_tap_gen (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (w_clear),
    .i_advance  (w_rd_en),
    .o_pixel    (w_pixel),
    .o_tap_addr (w_tap_addr)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_num_tiles  <= '0;
      r_tile       <= '0;
      r_oact_tile  <= '0;
      r_iact_addr  <= '0;
      r_last       <= 1'b0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_iact_valid <= 1'b0;
      r_oact_valid <= 1'b0;
      r_iacts      <= '0;
      r_wghts      <= '0;
    end else begin
      r_oact_valid <= 1'b0;
      if (w_rd_en) begin
        r_iact_addr <= r_iact_addr + 1'b1;
        r_last      <= w_fetch_last;
      end
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_num_tiles <= i_num_tiles;
            r_tile      <= '0;
            r_iact_addr <= '0;
            r_busy      <= 1'b1;
            r_state     <= (i_num_tiles == '0) ? StFin : StFetch;
          end
        end
        StFetch: r_state <= StLoad;
        StLoad: begin
          r_iacts      <= i_iact_rd_data;
          r_wghts      <= i_wght_rd_data;
          r_iact_valid <= 1'b1;
          r_state      <= StPresent;
        end
        StPresent: begin
          if (w_hs) begin
            r_iact_valid <= 1'b0;
            if (r_last) begin
              r_cnt   <= '0;
              r_state <= StDrain;
            end else begin
              r_state <= StLoad;
            end
          end
        end
        StDrain: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(OACT_LATENCY - 2)) begin
            r_oact_valid <= 1'b1;
            r_oact_tile  <= r_tile;
          end
          if (r_cnt == CNT_W'(OACT_LATENCY - 1)) begin
            if (r_tile == r_num_tiles - 1'b1) begin
              r_done  <= 1'b1;
              r_state <= StFin;
            end else begin
              r_tile  <= r_tile + 1'b1;
              r_state <= StFetch;
            end
          end
        end
        StFin: begin
          // An empty run arrives with done low and spends one extra cycle raising it.
          if (r_done) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_iact_rd_en   = w_rd_en;
  assign o_wght_rd_en   = w_rd_en;
  assign o_iact_rd_addr = r_iact_addr;
  assign o_wght_rd_addr = w_tap_addr;
  assign o_iacts        = r_iacts;
  assign o_wghts        = r_wghts;
  assign o_iact_valid   = r_iact_valid;
  assign o_oact_valid   = r_oact_valid;
  assign o_oact_tile    = r_oact_tile;

endmodule
